stv_stream_serializer: RTL and testbench

Transmit end of a wide-to-narrow ready/valid link. The block accepts one `BEATS*WIDTH`-bit word per input handshake and emits it as `BEATS` consecutive `WIDTH`-bit beats on a ready/valid output, least-significant beat first, with `last_out` flagging the final beat. All output-side signals (`valid_out`, `data_out`, `last_out`) are driven directly from flops. The block sits wherever a wide datapath must feed a narrow stream consumer. When a full combinational cut of `ready_in`→`ready_out` is needed, pair it with `stv_skid_buffer`.

---
 rtl/stv_stream_serializer.sv | 117 +++++++++++
 tb/tb_stv_stream_serializer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/stv_stream_serializer.sv
// stv_stream_serializer: wide-to-narrow ready/valid serializer.
// Takes one BEATS*WIDTH word per input handshake and emits it as BEATS
// WIDTH-bit beats, least-significant beat first. valid_out, last_out and
// data_out come straight from flops; ready_out is combinational so that
// the next word can be taken in the same cycle as the last-beat handshake.
module stv_stream_serializer #(
   parameter int WIDTH = 8,
   parameter int BEATS = 4
) (
   input  logic                   clk,
   input  logic                   arst_n,
   input  logic                   valid_in,
   output logic                   ready_out,
   input  logic [WIDTH*BEATS-1:0] data_in,
   input  logic                   ready_in,
   output logic                   valid_out,
   output logic [WIDTH-1:0]       data_out,
   output logic                   last_out
);

   // A single-beat word has no meaning for a serializer; refuse to build.
   generate
      if (BEATS < 2) begin : g_bad_beats
         $error("stv_stream_serializer: BEATS must be >= 2");
      end
   endgenerate

   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic                   valid_q, valid_d;
   logic                   last_q, last_d;
   logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
   logic [WIDTH*BEATS-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]       beat_cnt_inc;
   logic                   out_hs;

   assign valid_out = valid_q;
   assign last_out  = last_q;
   assign data_out  = shreg_q[WIDTH-1:0];

   // Next-state, beat bookkeeping, shift/load selection and ready_out.
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      last_d       = last_q;
      beat_cnt_d   = beat_cnt_q;
      shreg_d      = shreg_q;
      beat_cnt_inc = beat_cnt_q + CNT_W'(1);
      out_hs       = valid_q && ready_in;
      // ready_in -> ready_out is deliberate: it lets a new word load on the
      // last-beat handshake so back-to-back words have no bubble.
      ready_out    = (state_q == IDLE) || (valid_q && last_q && ready_in);

      case (state_q)
         IDLE: begin
            if (valid_in) begin
               state_d    = SEND;
               valid_d    = 1'b1;
               last_d     = 1'b0;
               beat_cnt_d = '0;
               shreg_d    = data_in;
            end
         end
         SEND: begin
            if (out_hs) begin
               if (last_q) begin
                  beat_cnt_d = '0;
                  last_d     = 1'b0;
                  if (valid_in) begin
                     shreg_d = data_in;
                  end else begin
                     state_d = IDLE;
                     valid_d = 1'b0;
                  end
               end else begin
                  shreg_d    = shreg_q >> WIDTH;
                  beat_cnt_d = beat_cnt_inc;
                  last_d     = (beat_cnt_inc == CNT_LAST);
               end
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
      endcase
   end

   // Control state; reset discards any partially sent word.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Data shift register; contents are don't-care while valid_out is low.
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
   end

endmodule

// File: tb/tb_stv_stream_serializer.sv
// Bench for stv_stream_serializer: directed scenarios plus randomized traffic
// against a queue-of-beats reference model, with a hold-rule scoreboard.
module tb_stv_stream_serializer;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        valid_in, ready_out, ready_in, valid_out, last_out;
   logic [31:0] data_in;
   logic [7:0]  data_out;

   logic        valid_in2, ready_out2, ready_in2, valid_out2, last_out2;
   logic [31:0] data_in2;
   logic [15:0] data_out2;

   always #5 clk = ~clk;

   stv_stream_serializer #(.WIDTH(8), .BEATS(4)) dut (
      .clk(clk), .arst_n(arst_n), .valid_in(valid_in), .ready_out(ready_out),
      .data_in(data_in), .ready_in(ready_in), .valid_out(valid_out),
      .data_out(data_out), .last_out(last_out)
   );

   stv_stream_serializer #(.WIDTH(16), .BEATS(2)) dut2 (
      .clk(clk), .arst_n(arst_n), .valid_in(valid_in2), .ready_out(ready_out2),
      .data_in(data_in2), .ready_in(ready_in2), .valid_out(valid_out2),
      .data_out(data_out2), .last_out(last_out2)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: beats of the word currently being sent, front = on the wire.
   logic [7:0] rem[$];
   // Beats that actually handshook on the DUT output: {last, data}.
   logic [8:0] obs[$];
   logic       prev_hold = 1'b0;
   logic       prev_l;
   logic [7:0] prev_d;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One clock cycle: drive at negedge, check just after, update model at posedge.
   task automatic step(input logic vin, input logic [31:0] din, input logic rin);
      logic exp_v, exp_r, out_hs, in_hs;
      @(negedge clk);
      valid_in = vin; data_in = din; ready_in = rin;
      #1;
      exp_v = (rem.size() > 0);
      exp_r = (rem.size() == 0) || (rem.size() == 1 && rin);
      check_eq("valid_out", {31'd0, valid_out}, {31'd0, exp_v});
      check_eq("ready_out", {31'd0, ready_out}, {31'd0, exp_r});
      if (exp_v) begin
         check_eq("data_out", {24'd0, data_out}, {24'd0, rem[0]});
         check_eq("last_out", {31'd0, last_out}, (rem.size() == 1) ? 32'd1 : 32'd0);
      end else begin
         check_eq("last_out_idle", {31'd0, last_out}, 32'd0);
      end
      if (prev_hold) begin
         check_eq("hold_valid", {31'd0, valid_out}, 32'd1);
         check_eq("hold_data", {24'd0, data_out}, {24'd0, prev_d});
         check_eq("hold_last", {31'd0, last_out}, {31'd0, prev_l});
      end
      prev_hold = valid_out && !rin;
      prev_d    = data_out;
      prev_l    = last_out;
      if (valid_out && rin) obs.push_back({last_out, data_out});
      out_hs = exp_v && rin;
      in_hs  = vin && exp_r;
      @(posedge clk);
      if (out_hs) void'(rem.pop_front());
      if (in_hs) for (int k = 0; k < 4; k++) rem.push_back(din[k*8 +: 8]);
   endtask

   // Pop four observed beats and compare against the word, LS beat first.
   task automatic check_word(input string tag, input logic [31:0] w);
      logic [8:0] b;
      check_eq({tag, "_avail"}, (obs.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
      if (obs.size() < 4) return;
      for (int k = 0; k < 4; k++) begin
         b = obs.pop_front();
         check_eq({tag, "_beat"}, {23'd0, b}, {23'd0, (k == 3), w[k*8 +: 8]});
      end
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] w;
      arst_n = 1'b0;
      valid_in = 1'b0; data_in = '0; ready_in = 1'b0;
      valid_in2 = 1'b0; data_in2 = '0; ready_in2 = 1'b0;
      #3;
      check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
      check_eq("rst_last", {31'd0, last_out}, 32'd0);
      check_eq("rst_ready", {31'd0, ready_out}, 32'd1);
      @(negedge clk);
      arst_n = 1'b1;

      // Single word.
      step(1'b1, 32'hDDCCBBAA, 1'b1);
      idle_steps(5);
      check_word("single", 32'hDDCCBBAA);
      check_eq("single_extra", obs.size(), 32'd0);

      // Backpressure while BB is presented.
      step(1'b1, 32'hDDCCBBAA, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
      idle_steps(4);
      check_word("bp", 32'hDDCCBBAA);

      // Back-to-back words.
      step(1'b1, 32'h44332211, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 32'h88776655, 1'b1);
      idle_steps(5);
      check_word("b2b_a", 32'h44332211);
      check_word("b2b_b", 32'h88776655);

      // Busy rejection, accepted only at the last-beat handshake.
      step(1'b1, 32'hDDCCBBAA, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      step(1'b1, 32'hFFFFFFFF, 1'b1);
      step(1'b1, 32'hFFFFFFFF, 1'b1);
      idle_steps(5);
      check_word("busy_a", 32'hDDCCBBAA);
      check_word("busy_b", 32'hFFFFFFFF);

      // Reset mid-word after AA handshakes.
      step(1'b1, 32'hDDCCBBAA, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      valid_in = 1'b0; ready_in = 1'b1;
      arst_n = 1'b0;
      #1;
      check_eq("midrst_valid", {31'd0, valid_out}, 32'd0);
      check_eq("midrst_ready", {31'd0, ready_out}, 32'd1);
      check_eq("midrst_last", {31'd0, last_out}, 32'd0);
      rem.delete();
      obs.delete();
      prev_hold = 1'b0;
      @(negedge clk);
      arst_n = 1'b1;
      step(1'b1, 32'h04030201, 1'b1);
      idle_steps(5);
      check_word("post_rst", 32'h04030201);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         w = $urandom;
         step($urandom_range(0, 99) < 40, w, $urandom_range(0, 99) < 70);
      end
      idle_steps(8);
      check_eq("rand_drained", rem.size(), 32'd0);

      // BEATS=2, WIDTH=16 instance.
      @(negedge clk);
      valid_in2 = 1'b1; data_in2 = 32'hBEEFCAFE; ready_in2 = 1'b1;
      #1;
      check_eq("b2_ready_idle", {31'd0, ready_out2}, 32'd1);
      check_eq("b2_valid_idle", {31'd0, valid_out2}, 32'd0);
      @(negedge clk);
      valid_in2 = 1'b0;
      #1;
      check_eq("b2_valid0", {31'd0, valid_out2}, 32'd1);
      check_eq("b2_data0", {16'd0, data_out2}, 32'h0000CAFE);
      check_eq("b2_last0", {31'd0, last_out2}, 32'd0);
      check_eq("b2_ready0", {31'd0, ready_out2}, 32'd0);
      @(negedge clk);
      #1;
      check_eq("b2_valid1", {31'd0, valid_out2}, 32'd1);
      check_eq("b2_data1", {16'd0, data_out2}, 32'h0000BEEF);
      check_eq("b2_last1", {31'd0, last_out2}, 32'd1);
      check_eq("b2_ready1", {31'd0, ready_out2}, 32'd1);
      @(negedge clk);
      #1;
      check_eq("b2_valid_end", {31'd0, valid_out2}, 32'd0);
      check_eq("b2_last_end", {31'd0, last_out2}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
